cfu_cmd_sequencer: RTL

//  Parametrised CFU command front-end between the CPU CFU bus and the TPU core plus its global buffers.
//  - Decodes function_id[9:3] ops: K/M/N registers, NUM_IN_BUFS input buffers, wide C readout by word select, start/poll, cycle count.
//  - Gives buffer ownership to the host or the core; the data muxes are outside this block.
//  - Adds error responses, a run timeout and a cycle counter.

---
 rtl/cfu_cmd_sequencer_if.sv | 31 +++
 rtl/cfu_cmd_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cfu_cmd_sequencer_if.sv
// CPU-side CFU command/response bus for cfu_cmd_sequencer.
//   master : the CPU (drives commands, accepts responses)
//   slave  : the sequencer (accepts commands, drives responses)
// Signals:
//   cmd_valid / cmd_ready              command handshake
//   cmd_payload_function_id [9:0]      op code lives in [9:3]
//   cmd_payload_inputs_0/1  [31:0]     operands
//   rsp_valid / rsp_ready              response handshake
//   rsp_payload_outputs_0   [31:0]     response data
interface cfu_cmd_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;

  modport master (
    output cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_payload_outputs_0
  );

  modport slave (
    input  cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0,
           cmd_payload_inputs_1, rsp_ready,
    output cmd_ready, rsp_valid, rsp_payload_outputs_0
  );
endinterface

// File: rtl/cfu_cmd_sequencer.sv
// CFU command front-end between the CPU CFU bus and a TPU core with its
// global buffers. Decodes function_id[9:3] into register, buffer, C-readout,
// start/poll and cycle-count operations, arbitrates buffer ownership
// (host_sel) and supervises core runs with a cycle counter and timeout.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   bus                 CFU command/response bus (slave side)
//   core_rst_n          core reset, active-low, held RST_CYCLES on soft reset/timeout
//   core_in_valid       one-cycle start pulse to the core
//   core_K/M/N          matrix dimensions
//   core_busy           core running
//   host_sel            1 = host owns buffers, 0 = core owns them
//   buf_wr_en           one-hot input-buffer write strobes
//   buf_index/wdata     host buffer index and write data
//   buf_rdata           input-buffer read data, buffer i at [32i+:32]
//   c_index / c_rdata   C buffer host read index and data
module cfu_cmd_sequencer #(
  parameter int unsigned ADDR_BITS   = 12,
  parameter int unsigned NUM_IN_BUFS = 2,
  parameter int unsigned C_BITS      = 128,
  parameter int unsigned BUF_LAT     = 1,
  parameter int unsigned RST_CYCLES  = 2,
  parameter int unsigned TIMEOUT     = 65535,
  parameter int unsigned BLOCKING    = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  cfu_cmd_sequencer_if.slave       bus,
  output logic                     core_rst_n,
  output logic                     core_in_valid,
  output logic [31:0]              core_K,
  output logic [31:0]              core_M,
  output logic [31:0]              core_N,
  input  logic                     core_busy,
  output logic                     host_sel,
  output logic [NUM_IN_BUFS-1:0]   buf_wr_en,
  output logic [ADDR_BITS-1:0]     buf_index,
  output logic [31:0]              buf_wdata,
  input  logic [NUM_IN_BUFS*32-1:0] buf_rdata,
  output logic [ADDR_BITS-1:0]     c_index,
  input  logic [C_BITS-1:0]        c_rdata
);

  localparam int unsigned C_WORDS = C_BITS / 32;
  localparam logic [31:0] ERR     = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE, S_EXEC, S_RD_WAIT, S_RST_HOLD, S_RUN, S_RSP
  } state_e;

  typedef enum logic [6:0] {
    OP_SOFT_RST = 7'd1,
    OP_SET_K    = 7'd2,
    OP_GET_K    = 7'd3,
    OP_SET_M    = 7'd4,
    OP_GET_M    = 7'd5,
    OP_SET_N    = 7'd6,
    OP_GET_N    = 7'd7,
    OP_WR_BUF   = 7'd8,
    OP_RD_BUF   = 7'd9,
    OP_START    = 7'd10,
    OP_STATUS   = 7'd11,
    OP_RD_C     = 7'd12,
    OP_CYCLES   = 7'd13
  } op_e;

  state_e      state;
  logic [6:0]  op_q;
  logic [31:0] in0_q;
  logic [31:0] in1_q;
  logic        cmd_ready;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic [31:0] hold_rsp;
  logic [31:0] wait_cnt;
  logic [31:0] hold_cnt;
  logic [31:0] cycle_cnt;
  logic        timeout_flag;
  logic        running;

  assign bus.cmd_ready             = cmd_ready;
  assign bus.rsp_valid             = rsp_valid;
  assign bus.rsp_payload_outputs_0 = rsp_data;

  logic [6:0]             op_in;
  logic                   accept;
  logic [7:0]             bid_q;
  logic                   bid_ok;
  logic                   w_ok;
  logic [NUM_IN_BUFS-1:0] wr_onehot;
  logic [31:0]            buf_sel;
  logic [31:0]            c_sel;

  assign op_in  = bus.cmd_payload_function_id[9:3];
  assign accept = bus.cmd_valid && cmd_ready && (state == S_IDLE);
  assign bid_q  = in0_q[31:24];
  assign bid_ok = {24'd0, bid_q} < 32'(NUM_IN_BUFS);
  assign w_ok   = in1_q < 32'(C_WORDS);

  always_comb begin
    wr_onehot = '0;
    buf_sel   = '0;
    c_sel     = '0;
    for (int unsigned i = 0; i < NUM_IN_BUFS; i++) begin
      wr_onehot[i] = (bid_q == 8'(i));
      if (bid_q == 8'(i)) buf_sel = buf_rdata[32*i +: 32];
    end
    for (int unsigned i = 0; i < C_WORDS; i++) begin
      if (in1_q == 32'(i)) c_sel = c_rdata[32*i +: 32];
    end
  end

  // Run supervision. The run is "live" once the start pulse has gone, so the
  // first RUN cycle already sees core_busy; it keeps going in the background
  // when responses are non-blocking.
  logic run_live;
  logic run_tick;
  logic run_done;
  logic run_timeout;

  assign run_live    = running && !core_in_valid;
  assign run_tick    = run_live && core_busy;
  assign run_done    = run_live && !core_busy;
  assign run_timeout = run_tick && (cycle_cnt == 32'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      op_q          <= '0;
      in0_q         <= '0;
      in1_q         <= '0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      hold_rsp      <= '0;
      wait_cnt      <= '0;
      hold_cnt      <= '0;
      cycle_cnt     <= '0;
      timeout_flag  <= 1'b0;
      running       <= 1'b0;
      core_rst_n    <= 1'b1;
      core_in_valid <= 1'b0;
      core_K        <= '0;
      core_M        <= '0;
      core_N        <= '0;
      host_sel      <= 1'b1;
      buf_wr_en     <= '0;
      buf_index     <= '0;
      buf_wdata     <= '0;
      c_index       <= '0;
    end else begin
      buf_wr_en     <= '0;
      core_in_valid <= 1'b0;

      // Core reset hold, shared by soft reset and timeout abort.
      if (!core_rst_n) begin
        if (hold_cnt == '0) core_rst_n <= 1'b1;
        else                hold_cnt   <= hold_cnt - 32'd1;
      end

      if (run_tick) cycle_cnt <= cycle_cnt + 32'd1;
      if (run_done || run_timeout) begin
        running  <= 1'b0;
        host_sel <= 1'b1;
      end
      if (run_timeout) begin
        timeout_flag <= 1'b1;
        core_rst_n   <= 1'b0;
        hold_cnt     <= 32'(RST_CYCLES - 1);
      end

      // FSM assignments come last so they take precedence over the monitor.
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q      <= op_in;
            in0_q     <= bus.cmd_payload_inputs_0;
            in1_q     <= bus.cmd_payload_inputs_1;
            cmd_ready <= 1'b0;
            state     <= S_EXEC;
            // Indices and the start pulse go out at accept so read latency
            // and the pulse-to-RUN spacing line up without extra states.
            if (!running) begin
              if (op_in == OP_WR_BUF || op_in == OP_RD_BUF)
                buf_index <= bus.cmd_payload_inputs_0[ADDR_BITS-1:0];
              if (op_in == OP_RD_C)
                c_index <= bus.cmd_payload_inputs_0[ADDR_BITS-1:0];
              if (op_in == OP_START && !core_busy) begin
                core_in_valid <= 1'b1;
                host_sel      <= 1'b0;
                running       <= 1'b1;
                cycle_cnt     <= '0;
              end
            end
          end
        end

        S_EXEC: begin
          state     <= S_RSP;
          rsp_valid <= 1'b1;
          rsp_data  <= ERR;
          case (op_q)
            OP_SOFT_RST: begin
              core_K       <= '0;
              core_M       <= '0;
              core_N       <= '0;
              cycle_cnt    <= '0;
              timeout_flag <= 1'b0;
              running      <= 1'b0;
              host_sel     <= 1'b1;
              core_rst_n   <= 1'b0;
              hold_cnt     <= 32'(RST_CYCLES - 1);
              hold_rsp     <= '0;
              rsp_valid    <= 1'b0;
              state        <= S_RST_HOLD;
            end
            OP_SET_K: begin core_K <= in0_q; rsp_data <= '0; end
            OP_SET_M: begin core_M <= in0_q; rsp_data <= '0; end
            OP_SET_N: begin core_N <= in0_q; rsp_data <= '0; end
            OP_GET_K: rsp_data <= core_K;
            OP_GET_M: rsp_data <= core_M;
            OP_GET_N: rsp_data <= core_N;
            OP_WR_BUF: begin
              if (!running && bid_ok) begin
                buf_wr_en <= wr_onehot;
                buf_wdata <= in1_q;
                rsp_data  <= '0;
              end
            end
            OP_RD_BUF, OP_RD_C: begin
              if (!running && ((op_q == OP_RD_BUF) ? bid_ok : w_ok)) begin
                rsp_valid <= 1'b0;
                wait_cnt  <= 32'(BUF_LAT - 1);
                state     <= S_RD_WAIT;
              end
            end
            OP_START: begin
              // core_in_valid still high here means the pulse was issued.
              if (core_in_valid) begin
                if (BLOCKING != 0) begin
                  rsp_valid <= 1'b0;
                  state     <= S_RUN;
                end else begin
                  rsp_data <= '0;
                end
              end
            end
            OP_STATUS: rsp_data <= {30'd0, timeout_flag, core_busy | running};
            OP_CYCLES: rsp_data <= cycle_cnt;
            default:   rsp_data <= ERR;
          endcase
        end

        S_RD_WAIT: begin
          if (wait_cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_data  <= (op_q == OP_RD_C) ? c_sel : buf_sel;
            state     <= S_RSP;
          end else begin
            wait_cnt <= wait_cnt - 32'd1;
          end
        end

        S_RST_HOLD: begin
          if (core_rst_n || hold_cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_data  <= hold_rsp;
            state     <= S_RSP;
          end
        end

        S_RUN: begin
          if (run_timeout) begin
            hold_rsp <= ERR;
            state    <= S_RST_HOLD;
          end else if (run_done || !running) begin
            rsp_valid <= 1'b1;
            rsp_data  <= cycle_cnt;
            state     <= S_RSP;
          end
        end

        S_RSP: begin
          if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
